// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the front-end branch sequencer; the hazard unit and PC mux
// use the same PC_SEL_* codes.
package branch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    SLOT    = 2'd2
  } seq_state_t;

  typedef enum logic {
    KIND_COND = 1'b0,
    KIND_JREG = 1'b1
  } br_kind_t;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_REG = 2'b11;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  q <= '0;
    else if (clr)             q <= '0;
    else if (inc && q != '1)  q <= q + 1'b1;
  end

endmodule

// File: rtl/branch_sequencer.sv
// Front-end control sequencer: PC source, PC/IF-ID enables, delay slot, squash,
// branch statistics and sticky error flag.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_jreg,
  input  logic             hazard_stall,
  input  logic             cond_valid,
  input  logic             cond_taken,
  input  logic             stat_clr,
  output logic             pc_ld,
  output logic             if_id_ld,
  output logic [1:0]       pc_sel,
  output logic             squash,
  output logic             in_delay_slot,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic             err_sticky
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  seq_state_t state, state_nxt;
  br_kind_t   kind, kind_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       br_inc, tk_inc, err_evt, cti;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      kind     <= KIND_COND;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    kind_nxt      = kind;
    wait_nxt      = wait_cnt;
    pc_ld         = 1'b1;
    if_id_ld      = 1'b1;
    pc_sel        = PC_SEL_PC4;
    squash        = 1'b0;
    in_delay_slot = 1'b0;
    br_inc        = 1'b0;
    tk_inc        = 1'b0;
    err_evt       = 1'b0;
    cti           = id_branch | id_jump | id_jreg;

    unique case (state)
      IDLE: begin
        if (id_jump) begin
          pc_sel    = PC_SEL_JMP;
          state_nxt = SLOT;
        end else if (id_jreg || id_branch) begin
          // PC+4 here fetches the delay slot's successor (PC+8) speculatively
          kind_nxt  = id_jreg ? KIND_JREG : KIND_COND;
          wait_nxt  = '0;
          state_nxt = RESOLVE;
        end
      end
      RESOLVE: begin
        in_delay_slot = 1'b1;
        err_evt       = cti;
        if (cond_valid) begin
          state_nxt = IDLE;
          if (kind == KIND_JREG) begin
            pc_sel = PC_SEL_REG;
            squash = 1'b1;
          end else begin
            br_inc = 1'b1;
            if (cond_taken) begin
              pc_sel = PC_SEL_BR;
              squash = 1'b1;
              tk_inc = 1'b1;
            end
          end
        end else if (wait_cnt == WAIT_LIM) begin
          // condition never arrived: fall through as not taken
          err_evt   = 1'b1;
          br_inc    = (kind == KIND_COND);
          state_nxt = IDLE;
        end else begin
          pc_ld    = 1'b0;
          if_id_ld = 1'b0;
          wait_nxt = wait_cnt + 4'd1;
        end
      end
      SLOT: begin
        in_delay_slot = 1'b1;
        err_evt       = cti;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (hazard_stall) begin
      state_nxt = state;
      kind_nxt  = kind;
      wait_nxt  = wait_cnt;
      pc_ld     = 1'b0;
      if_id_ld  = 1'b0;
      squash    = 1'b0;
      pc_sel    = PC_SEL_PC4;
      br_inc    = 1'b0;
      tk_inc    = 1'b0;
      err_evt   = 1'b0;
    end

    if (reset) begin
      pc_ld         = 1'b0;
      if_id_ld      = 1'b0;
      squash        = 1'b0;
      pc_sel        = PC_SEL_PC4;
      in_delay_slot = 1'b0;
    end
  end

  // an error event in the same cycle as stat_clr still leaves the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_sticky <= 1'b0;
    else if (err_evt)  err_sticky <= 1'b1;
    else if (stat_clr) err_sticky <= 1'b0;
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk (clk), .rst (reset), .inc (br_inc), .clr (stat_clr), .q (br_count)
  );

  sat_counter #(.W(CNT_W)) u_tk_cnt (
    .clk (clk), .rst (reset), .inc (tk_inc), .clr (stat_clr), .q (taken_count)
  );

endmodule
